uart_tx_frame_arbiter: RTL and testbench

- Shares the single uart_tx transmitter between NREQ byte-frame requesters, e.g. the ALU result/flags/status responder and a debug/echo path.
- Grants round-robin and holds the grant for a whole frame.
- Drives a single-cycle tx_start per byte, then waits for tx_done_tick before the next byte.
- A watchdog aborts the frame if the transmitter never reports completion.

---
 rtl/uart_tx_frame_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_frame_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that lends one uart_tx to NREQ byte-frame requesters, holding the grant
// for a whole frame and aborting it through a watchdog if tx_done never comes back.
module uart_tx_frame_arbiter #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned MAX_FRAME  = 4,
    parameter int unsigned TX_TIMEOUT = 200000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_BITS-1:0] byte_data,
    input  logic [NREQ-1:0]           byte_last,
    output logic [NREQ-1:0]           byte_ack,
    output logic [NREQ-1:0]           gnt,
    output logic                      tx_start,
    output logic [DATA_BITS-1:0]      tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(MAX_FRAME) + 1;
    localparam int unsigned TmrW = $clog2(TX_TIMEOUT) + 1;

    localparam logic [CntW-1:0] CntMax   = CntW'(MAX_FRAME);
    localparam logic [TmrW-1:0] TmrLimit = TmrW'(TX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StRelease
    } state_e;

    state_e                state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [IdxW-1:0]       last_served_q, last_served_d;
    logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;
    logic                  last_q, last_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [TmrW-1:0]       timer_q, timer_d;

    logic [DATA_BITS-1:0]  bytes [NREQ];
    logic                  sel_vld;
    logic [IdxW-1:0]       sel_idx;
    logic [IdxW-1:0]       cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign bytes[g] = byte_data[g*DATA_BITS +: DATA_BITS];
    end

    // First requesting index strictly after the last one served, wrapping modulo NREQ.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdxW'((32'(last_served_q) + k) % NREQ);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        idx_d         = idx_q;
        last_served_d = last_served_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timer_d       = timer_q;
        err_timeout   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sel_vld) begin
                    gnt_d     = NREQ'(1) << sel_idx;
                    idx_d     = sel_idx;
                    tx_data_d = bytes[sel_idx];
                    last_d    = byte_last[sel_idx];
                    cnt_d     = CntW'(1);
                    state_d   = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
                // A completion in the same cycle as the deadline still counts as success.
                if (tx_done) begin
                    if (last_q || cnt_q == CntMax) begin
                        gnt_d   = '0;
                        state_d = StRelease;
                    end else begin
                        tx_data_d = bytes[idx_q];
                        last_d    = byte_last[idx_q];
                        cnt_d     = cnt_q + 1'b1;
                        state_d   = StLaunch;
                    end
                end else if (timer_q == TmrLimit) begin
                    err_timeout = 1'b1;
                    gnt_d       = '0;
                    state_d     = StRelease;
                end
            end
            StRelease: begin
                last_served_d = idx_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            gnt_q         <= '0;
            idx_q         <= '0;
            last_served_q <= IdxW'(NREQ - 1);
            tx_data_q     <= '0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            idx_q         <= idx_d;
            last_served_q <= last_served_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
        end
    end

    // gnt_q is one-hot on the granted requester, so it doubles as the ack mask.
    assign byte_ack = (state_q == StLaunch) ? gnt_q : '0;
    assign gnt      = gnt_q;
    assign tx_start = (state_q == StLaunch);
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter: requester byte models, a uart_tx responder with a
// programmable done delay, and an event monitor feeding hand-computed expectations.
module tb_uart_tx_frame_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXF = 4;
    localparam int unsigned TOUT = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [NREQ*DW-1:0] byte_data;
    logic [NREQ-1:0]  byte_last;
    logic [NREQ-1:0]  byte_ack;
    logic [NREQ-1:0]  gnt;
    logic             tx_start;
    logic [DW-1:0]    tx_data;
    logic             tx_done;
    logic             busy;
    logic             err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc;
    int done_delay = 0;
    int done_due   = -1;
    int done_cyc   = 0;

    logic [7:0] mem [2][8];
    int len [2];
    int ptr [2];

    int n_start, n_err, err_cyc, last_busy_cyc, gnt0_cyc;
    int ack_cnt [2];
    logic [7:0] sent_q [$];
    int start_q [$];
    int gnt_seq [$];
    logic [1:0] gnt_prev;

    always #5 clk = ~clk;

    uart_tx_frame_arbiter #(
        .NREQ       (NREQ),
        .DATA_BITS  (DW),
        .MAX_FRAME  (MAXF),
        .TX_TIMEOUT (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ack    (byte_ack),
        .gnt         (gnt),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic present();
        for (int i = 0; i < 2; i++) begin
            byte_data[i*DW +: DW] = mem[i][ptr[i] % 8];
            byte_last[i] = (len[i] != 0) && ((ptr[i] % len[i]) == len[i] - 1);
        end
    endtask

    task automatic clear_stats();
        n_start = 0; n_err = 0; err_cyc = 0; last_busy_cyc = 0; gnt0_cyc = 0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        sent_q.delete(); start_q.delete(); gnt_seq.delete();
    endtask

    task automatic launch_req(input logic [1:0] r, output int t);
        @(posedge clk); #2;
        req = r;
        t = cyc;
    endtask

    task automatic drop_req();
        @(posedge clk); #2;
        req = '0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b0; req = '0; done_due = -1; done_delay = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    // uart_tx model: tx_done pulses done_delay cycles after the observed tx_start.
    initial begin
        cyc = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            tx_done = (cyc == done_due);
            if (tx_done) done_cyc = cyc;
        end
    end

    initial begin
        gnt_prev = '0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                n_start++;
                sent_q.push_back(tx_data);
                start_q.push_back(cyc);
                if (done_delay != 0) done_due = cyc + done_delay;
            end
            for (int i = 0; i < 2; i++) begin
                if (byte_ack[i] === 1'b1) begin
                    ack_cnt[i]++;
                    ptr[i]++;
                end
            end
            present();
            if (err_timeout === 1'b1) begin
                n_err++;
                err_cyc = cyc;
            end
            if (gnt != 0 && gnt_prev == 0) gnt_seq.push_back(int'(gnt));
            if (gnt == 2'b01) gnt0_cyc++;
            gnt_prev = gnt;
            if (busy) last_busy_cyc = cyc;
        end
    end

    initial begin
        int t;
        int e;
        reset = 1'b0;
        req = '0;
        for (int i = 0; i < 8; i++) begin
            mem[0][i] = 8'h10 + 8'(i);
            mem[1][i] = 8'hB0 + 8'(i);
        end
        len[0] = 1; len[1] = 1; ptr[0] = 0; ptr[1] = 0;
        present();
        clear_stats();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_tx_start", tx_start, 1'b0);
        check_eq("rst_byte_ack", byte_ack, 2'b00);
        check_eq("rst_err", err_timeout, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_no_req_busy", busy, 1'b0);
        check_eq("idle_no_req_start", tx_start, 1'b0);

        // 1: single requester, 3-byte frame, 160-cycle transmitter
        mem[0][0] = 8'h2A; mem[0][1] = 8'h80; mem[0][2] = 8'h55;
        len[0] = 3; ptr[0] = 0; ptr[1] = 0;
        present();
        clear_stats();
        done_delay = 160;
        launch_req(2'b01, t);
        @(negedge clk);
        check_eq("t1_req_cycle_busy", busy, 1'b0);
        @(negedge clk);
        check_eq("t1_gnt", gnt, 2'b01);
        check_eq("t1_tx_start", tx_start, 1'b1);
        check_eq("t1_byte_ack", byte_ack, 2'b01);
        check_eq("t1_tx_data0", tx_data, 8'h2A);
        drop_req();
        wait_idle("t1_idle", 1000);
        check_eq("t1_n_start", n_start, 3);
        if (sent_q.size() == 3) begin
            check_eq("t1_byte1", sent_q[1], 8'h80);
            check_eq("t1_byte2", sent_q[2], 8'h55);
            check_eq("t1_last_start_cyc", start_q[2], t + 323);
        end
        check_eq("t1_ack0", ack_cnt[0], 3);
        check_eq("t1_ack1", ack_cnt[1], 0);
        check_eq("t1_gnt_cycles", gnt0_cyc, 483);
        check_eq("t1_gnt_rises", gnt_seq.size(), 1);
        check_eq("t1_busy_fall", last_busy_cyc, done_cyc + 1);
        check_eq("t1_no_err", n_err, 0);

        // 2: both requesting, 1-byte frames alternate 0,1,0,1 after reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mem[0][i] = 8'hA0 + 8'(i);
            mem[1][i] = 8'hB0 + 8'(i);
        end
        len[0] = 1; len[1] = 1; ptr[0] = 0; ptr[1] = 0;
        present();
        clear_stats();
        done_delay = 5;
        launch_req(2'b11, t);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (gnt_seq.size() >= 4) break;
        end
        drop_req();
        wait_idle("t2_idle", 200);
        check_eq("t2_n_grants", gnt_seq.size(), 4);
        if (gnt_seq.size() == 4) begin
            check_eq("t2_gnt0", gnt_seq[0], 1);
            check_eq("t2_gnt1", gnt_seq[1], 2);
            check_eq("t2_gnt2", gnt_seq[2], 1);
            check_eq("t2_gnt3", gnt_seq[3], 2);
            check_eq("t2_frame_gap", start_q[1] - start_q[0], 8);
            check_eq("t2_data1", sent_q[1], 8'hB0);
            check_eq("t2_data2", sent_q[2], 8'hA1);
        end
        check_eq("t2_ack0", ack_cnt[0], 2);
        check_eq("t2_ack1", ack_cnt[1], 2);

        // 3: byte_last never set, frame capped at MAX_FRAME bytes
        for (int i = 0; i < 8; i++) mem[0][i] = 8'h10 + 8'(i);
        len[0] = 0; ptr[0] = 0;
        present();
        clear_stats();
        done_delay = 5;
        launch_req(2'b01, t);
        drop_req();
        wait_idle("t3_idle", 200);
        check_eq("t3_n_start", n_start, 4);
        check_eq("t3_ack0", ack_cnt[0], 4);
        if (sent_q.size() == 4) check_eq("t3_byte3", sent_q[3], 8'h13);
        check_eq("t3_gnt_rises", gnt_seq.size(), 1);
        check_eq("t3_no_err", n_err, 0);

        // 4: transmitter never completes, watchdog aborts
        len[0] = 2; ptr[0] = 0;
        present();
        clear_stats();
        done_delay = 0;
        done_due = -1;
        launch_req(2'b01, t);
        drop_req();
        e = 0;
        for (int k = 0; k < int'(TOUT) + 20; k++) begin
            @(negedge clk);
            if (err_timeout) begin
                e = 1;
                break;
            end
        end
        check_eq("t4_err_seen", err_timeout, 1'b1);
        @(negedge clk);
        check_eq("t4_err_pulse", err_timeout, 1'b0);
        check_eq("t4_gnt_released", gnt, 2'b00);
        @(negedge clk);
        check_eq("t4_idle", busy, 1'b0);
        if (e == 1 && start_q.size() == 1) check_eq("t4_err_delay", err_cyc - start_q[0], TOUT);
        check_eq("t4_n_err", n_err, 1);
        check_eq("t4_n_start", n_start, 1);
        len[1] = 1; ptr[1] = 0;
        present();
        clear_stats();
        done_delay = 5;
        launch_req(2'b10, t);
        drop_req();
        wait_idle("t4_next_idle", 200);
        check_eq("t4_next_n_start", n_start, 1);
        if (gnt_seq.size() >= 1) check_eq("t4_next_gnt", gnt_seq[0], 2);
        if (sent_q.size() >= 1) check_eq("t4_next_data", sent_q[0], 8'hB0);
        check_eq("t4_next_no_err", n_err, 0);

        // 5: tx_done lands exactly on the watchdog deadline
        mem[0][0] = 8'hC3; mem[0][1] = 8'h3C;
        len[0] = 2; ptr[0] = 0;
        present();
        clear_stats();
        done_delay = TOUT;
        launch_req(2'b01, t);
        drop_req();
        wait_idle("t5_idle", 1000);
        check_eq("t5_no_err", n_err, 0);
        check_eq("t5_n_start", n_start, 2);
        if (sent_q.size() == 2) begin
            check_eq("t5_byte1", sent_q[1], 8'h3C);
            check_eq("t5_gap", start_q[1] - start_q[0], TOUT + 1);
        end

        // 6: asynchronous reset mid-frame, then priority restarts at requester 0
        len[0] = 2; ptr[0] = 0;
        present();
        clear_stats();
        done_delay = 160;
        launch_req(2'b01, t);
        drop_req();
        repeat (10) @(negedge clk);
        check_eq("t6_mid_busy", busy, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_eq("t6_rst_gnt", gnt, 2'b00);
        check_eq("t6_rst_busy", busy, 1'b0);
        check_eq("t6_rst_start", tx_start, 1'b0);
        done_due = -1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        len[0] = 1; len[1] = 1; ptr[0] = 0; ptr[1] = 0;
        present();
        clear_stats();
        done_delay = 5;
        launch_req(2'b11, t);
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_first_gnt", gnt, 2'b01);
        drop_req();
        wait_idle("t6_idle", 200);
        launch_req(2'b10, t);
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_second_gnt", gnt, 2'b10);
        drop_req();
        wait_idle("t6_idle2", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
